// File: rtl/seqgen_pkg.sv
// Shared types and constants for the 01[0*]1 pattern generator and its display.
package seqgen_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START0,
      START1,
      ZEROS,
      STOP1
   } seqgen_state_t;

   localparam logic SIG_IDLE = 1'b1;

   // Segments are bit6=g .. bit0=a and active-high; the detector's display uses this same table.
   localparam logic [6:0] SEG7_DIGITS [10] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
   };

   function automatic logic [6:0] seg7(input logic [3:0] digit);
      logic [6:0] seg;
      seg = '0;
      if (digit < 4'd10) begin
         seg = SEG7_DIGITS[digit];
      end
      return seg;
   endfunction

endpackage

// File: rtl/sequence_generator_bcd2_counter.sv
// Two-digit BCD counter, 00..99 with wrap, synchronous active-low reset.
module bcd2_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   output logic [3:0] ones,
   output logic [3:0] tens
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         ones <= 4'd0;
         tens <= 4'd0;
      end else if (inc) begin
         if (ones == 4'd9) begin
            ones <= 4'd0;
            tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
         end else begin
            ones <= ones + 4'd1;
         end
      end
   end

endmodule

// File: rtl/sequence_generator.sv
// Serial 0,1,N zeros,1 frame transmitter with a BCD count of completed frames on 7-segment outputs.
module sequence_generator
   import seqgen_pkg::*;
#(
   parameter int MAX_ZEROS = 15,
   parameter int ZW        = $clog2(MAX_ZEROS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic          req_valid,
   input  logic [ZW-1:0] req_zeros,
   output logic          req_ready,
   output logic          sig_out,
   output logic          busy,
   output logic          frame_done,
   output logic [6:0]    disp0,
   output logic [6:0]    disp1
);

   localparam logic [ZW-1:0] MAX_Z = ZW'(MAX_ZEROS);

   seqgen_state_t  state_reg;
   logic [ZW-1:0]  zcnt_reg;
   logic [3:0]     digit [2];
   logic [6:0]     seg   [2];

   assign req_ready  = (state_reg == IDLE) && ena;
   assign busy       = (state_reg != IDLE);
   assign frame_done = (state_reg == STOP1) && ena;

   // Line level is a pure decode of the state, so it naturally holds while ena is low.
   always_comb begin
      sig_out = SIG_IDLE;
      if (state_reg == START0 || state_reg == ZEROS) begin
         sig_out = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         zcnt_reg  <= '0;
      end else if (ena) begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  state_reg <= START0;
                  zcnt_reg  <= (req_zeros > MAX_Z) ? MAX_Z : req_zeros;
               end
            end
            START0: state_reg <= START1;
            START1: state_reg <= (zcnt_reg == '0) ? STOP1 : ZEROS;
            ZEROS: begin
               zcnt_reg <= zcnt_reg - ZW'(1);
               if (zcnt_reg == ZW'(1)) begin
                  state_reg <= STOP1;
               end
            end
            STOP1:   state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   bcd2_counter u_count (
      .clk  (clk),
      .rst  (rst),
      .inc  (frame_done),
      .ones (digit[0]),
      .tens (digit[1])
   );

   for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      assign seg[gi] = seg7(digit[gi]);
   end

   assign disp0 = seg[0];
   assign disp1 = seg[1];

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench: requests are queued by stimulus, expanded into expected line bits and checked each cycle.
module tb_sequence_generator;

   localparam int MAXZ = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena = 1'b1;
   logic       req_valid = 1'b0;
   logic [3:0] req_zeros = 4'd0;
   logic       req_ready, sig_out, busy, frame_done;
   logic [6:0] disp0, disp1;

   int checks = 0;
   int errors = 0;

   sequence_generator #(.MAX_ZEROS(MAXZ)) dut (
      .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_zeros(req_zeros),
      .req_ready(req_ready), .sig_out(sig_out), .busy(busy), .frame_done(frame_done),
      .disp0(disp0), .disp1(disp1)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // Reference model: pending request lengths, and remaining line bits {last, bit}.
   int       req_q [$];
   bit [1:0] exp_q [$];
   int       model_count = 0;
   int       accept_cnt = 0;
   int       frames_done = 0;
   bit       armed = 0;
   bit       rand_ena = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare this cycle, then advance the model across the coming edge.
   bit       m_empty;
   bit [1:0] m_bit;
   int       m_nz, m_req;
   always @(negedge clk) begin
      m_empty = (exp_q.size() == 0);
      if (armed) begin
         chk("sig_out",    sig_out,    m_empty ? 1 : int'(exp_q[0][0]));
         chk("busy",       busy,       !m_empty);
         chk("frame_done", frame_done, !m_empty && exp_q[0][1] && ena);
         chk("req_ready",  req_ready,  m_empty && ena);
         chk("disp0",      disp0,      seg_tab[model_count % 10]);
         chk("disp1",      disp1,      seg_tab[model_count / 10]);
      end
      if (!rst) begin
         armed = 1;
         exp_q.delete();
         model_count = 0;
      end else if (ena) begin
         if (!m_empty) begin
            m_bit = exp_q.pop_front();
            if (m_bit[1]) begin
               model_count = (model_count + 1) % 100;
               frames_done++;
               $display("frame %0d complete, count=%02d", frames_done, model_count);
            end
         end else if (req_valid) begin
            if (req_q.size() == 0) begin
               chk("unexpected_request", 1, 0);
            end else begin
               m_req = req_q.pop_front();
               m_nz  = (m_req > MAXZ) ? MAXZ : m_req;
               exp_q.push_back(2'b00);
               exp_q.push_back(2'b01);
               for (int i = 0; i < m_nz; i++) exp_q.push_back(2'b00);
               exp_q.push_back(2'b11);
               accept_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      if (rand_ena) ena = ($urandom_range(0, 4) != 0);
   endtask

   task automatic send_burst(input int n, input int cnt);
      int start;
      int k;
      start = accept_cnt;
      for (int i = 0; i < cnt; i++) req_q.push_back(n);
      req_zeros = 4'(n);
      req_valid = 1'b1;
      k = 0;
      while (accept_cnt - start < cnt && k < 5000) begin
         tick();
         k++;
      end
      if (k >= 5000) chk("accept_timeout", accept_cnt - start, cnt);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || req_q.size() != 0) && k < 5000) begin
         tick();
         k++;
      end
      if (k >= 5000) chk("idle_timeout", exp_q.size(), 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("reset_disp0", disp0, 7'b0111111);
      chk("reset_disp1", disp1, 7'b0111111);
      chk("reset_sig",   sig_out, 1);

      send_burst(2, 1);  wait_idle();
      chk("basic_disp0", disp0, 7'b0000110);
      send_burst(0, 1);  wait_idle();
      send_burst(12, 1); wait_idle();
      send_burst(15, 1); wait_idle();
      send_burst(13, 1); wait_idle();
      send_burst(1, 3);  wait_idle();

      // Stall three cycles inside the zero run.
      send_burst(3, 1);
      tick(); tick();
      ena = 1'b0;
      tick(); tick(); tick();
      ena = 1'b1;
      wait_idle();

      rand_ena = 1;
      for (int f = 0; f < 20; f++) begin
         send_burst($urandom_range(0, 15), 1);
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle();
      rand_ena = 0;
      ena = 1'b1;
      tick();

      // Reset while the zero run is in progress.
      send_burst(10, 1);
      tick(); tick(); tick(); tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("midreset_sig",   sig_out, 1);
      chk("midreset_disp0", disp0, 7'b0111111);
      tick();

      send_burst(0, 100); wait_idle();
      chk("wrap_disp1", disp1, 7'b0111111);
      chk("wrap_disp0", disp0, 7'b0111111);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
